sir_arbiter: RTL and testbench
==============================

# sir_arbiter

Shares the single SIR CSR bus (sir_sel/sir_addr/sir_read/sir_wdat → sir_rdat/sir_dack) among N_REQ requesters, for example the AXI-Lite CSR bridge, a boot-time config loader and a debug port. It sits between those masters and the register file.

- Grants one transaction at a time, round-robin.
- Drives the downstream SIR strobe and waits for the acknowledge.
- Returns read data and ack to the granted requester.
- Terminates hung transactions with an error after a fixed timeout.

## Interface
Parameters:
- N_REQ, 4: number of requesters (2..8).
- ADDR_W, 16: SIR address width.
- DATA_W, 32: SIR data width.
- TIMEOUT, 255: maximum cycles sir_sel may stay high without sir_dack (≥2).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous, active-low.
- req_sel  in  N_REQ  per-requester transaction request, held until its req_dack.
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i belongs to requester i.
- req_read  in  N_REQ  1 = read, 0 = write.
- req_wdat  in  N_REQ*DATA_W  packed write data.
- req_rdat  out  DATA_W  read data, shared; valid with any req_dack bit.
- req_dack  out  N_REQ  one-cycle completion pulse to the granted requester.
- req_err  out  N_REQ  one-cycle pulse, coincident with req_dack, on timeout.
- sir_sel  out  1  downstream strobe, held high until dack or timeout.
- sir_addr  out  ADDR_W  downstream address.
- sir_read  out  1  downstream read flag.
- sir_wdat  out  DATA_W  downstream write data.
- sir_rdat  in  DATA_W  downstream read data, valid with sir_dack.
- sir_dack  in  1  downstream acknowledge pulse.
- grant_id  out  $clog2(N_REQ)  index of the current/last granted requester.
- busy  out  1  high in ISSUE and DONE.
- timeout_cnt  out  16  saturating count of timed-out transactions.

## Operation
FSM states: IDLE, ISSUE, DONE.

- IDLE
  - If any req_sel is high, pick the winner: round-robin search starting at rr_ptr.
  - Register the winner's addr/read/wdat into the sir_* outputs.
  - Set sir_sel=1, grant_id=winner, rr_ptr=(winner+1) mod N_REQ; go to ISSUE.
  - With no request, stay in IDLE with all sir_* held at their last values and sir_sel=0.
- ISSUE
  - Hold all sir_* stable.
  - wd_cnt increments every cycle.
  - On sir_dack:
    - sir_sel=0.
    - req_rdat = sir_rdat if sir_read, else 0.
    - req_dack[grant_id]=1; go to DONE.
  - On wd_cnt==TIMEOUT-1 with no sir_dack:
    - sir_sel=0, req_rdat=32'hFFFF_FFFF.
    - req_dack[grant_id]=1, req_err[grant_id]=1.
    - timeout_cnt+1, saturating at 16'hFFFF; go to DONE.
  - sir_dack and timeout in the same cycle: dack wins, no error.
- DONE
  - One turnaround cycle. req_dack/req_err are 0 again. wd_cnt cleared.
  - Requests are not sampled; go to IDLE.
- Stray sir_dack in IDLE or DONE: ignored, no output change.
- Requester protocol:
  - The requester must keep req_sel and its fields stable until req_dack.
  - It deasserts req_sel, or presents a new transaction, in the cycle after req_dack.
  - Dropping req_sel while in ISSUE does not abort; the transaction completes and req_dack still pulses.
- rr_ptr changes only on a grant. A requester losing arbitration keeps req_sel high and is served within N_REQ grants.

## Timing
- Reset values (asynchronous, rst_n low):
  - state=IDLE, rr_ptr=0.
  - sir_sel=0, sir_addr=0, sir_read=0, sir_wdat=0.
  - req_rdat=0, req_dack=0, req_err=0.
  - grant_id=0, busy=0, timeout_cnt=0, wd_cnt=0.
- Request latency: req_sel high at cycle t (IDLE) → sir_sel high at t+1.
- Ack latency: sir_dack at cycle k → req_dack/req_rdat at k+1, with sir_sel low from k+1.
- Next grant sampled at k+2 at the earliest. Back-to-back throughput is 1 transaction per (dack latency + 3) cycles.
- Timeout: sir_sel is high for exactly TIMEOUT cycles, then req_err and req_dack pulse in the next cycle.
- Reset mid-ISSUE:
  - sir_sel drops immediately (async), and no req_dack is issued.
  - After rst_n deassertion, arbitration restarts at requester 0.

## Structure
- Package sir_pkg holds:
  - SIR_ADDR_W=16, SIR_DATA_W=32, SIR_TIMEOUT_DEF=255.
  - SIR_ERR_RDATA=32'hFFFF_FFFF.
  - FSM state typedef (IDLE/ISSUE/DONE).
- One sub-module, sir_rr_pick: combinational round-robin picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: valid and winner index.
  - Reusable by other SIR/AXI sharing blocks.
- Everything else (FSM, watchdog, output registers) lives in sir_arbiter.

## Test plan
- Single read: req_sel[1], addr 16'h0040, slave dacks 3 cycles after sir_sel with rdat 32'h1234_5678 → sir_addr=0040, sir_read=1; req_dack[1] one pulse; req_rdat=1234_5678; req_err=0.
- All four requesters request simultaneously with different addresses, slave dacks after 1 cycle → grant order 0,1,2,3; each req_dack bit pulses exactly once; no sir_sel overlap; DONE gap observed between transactions.
- Round-robin fairness: req 0 and 2 held continuously for 10 transactions → grants alternate 0,2,0,2…; neither is starved.
- Timeout: TIMEOUT=8, slave never dacks on a write to 16'h00FC → sir_sel high 8 cycles; req_dack[0] and req_err[0] pulse together; req_rdat=FFFF_FFFF; timeout_cnt=1; next request is served normally.
- Dack on the timeout cycle (dack arrives in sir_sel cycle TIMEOUT) → normal completion, req_err=0, timeout_cnt unchanged. A stray sir_dack while IDLE → no req_dack.
- Reset assertion during ISSUE → sir_sel=0 in the same cycle with all outputs at reset values; after release, req 3 and req 0 pending → req 0 granted first.

Source files
------------

// File: rtl/sir_pkg.sv
// Shared constants and types for the SIR CSR bus sharing blocks.
package sir_pkg;

  localparam int SIR_ADDR_W      = 16;
  localparam int SIR_DATA_W      = 32;
  localparam int SIR_TIMEOUT_DEF = 255;

  localparam logic [31:0] SIR_ERR_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } sir_state_e;

endpackage

// File: rtl/sir_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around modulo N.
module sir_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  // Scan from the farthest offset down so the nearest request to ptr is the
  // last assignment and therefore the winner.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = IW'((int'(ptr) + i) % N);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/sir_arbiter.sv
// Round-robin arbiter sharing one SIR CSR bus among N_REQ requesters, with a
// watchdog that terminates hung transactions with an error response.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; pick a winner when any req_sel is high
// ST_ISSUE | sir_sel high, waiting for sir_dack or watchdog expiry
// ST_DONE  | one turnaround cycle after completion; requests not sampled
module sir_arbiter
  import sir_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = SIR_ADDR_W,
  parameter int DATA_W  = SIR_DATA_W,
  parameter int TIMEOUT = SIR_TIMEOUT_DEF,
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_sel,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0]          req_read,
  input  logic [N_REQ*DATA_W-1:0]   req_wdat,
  output logic [DATA_W-1:0]         req_rdat,
  output logic [N_REQ-1:0]          req_dack,
  output logic [N_REQ-1:0]          req_err,
  output logic                      sir_sel,
  output logic [ADDR_W-1:0]         sir_addr,
  output logic                      sir_read,
  output logic [DATA_W-1:0]         sir_wdat,
  input  logic [DATA_W-1:0]         sir_rdat,
  input  logic                      sir_dack,
  output logic [IW-1:0]             grant_id,
  output logic                      busy,
  output logic [15:0]               timeout_cnt
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(SIR_ERR_RDATA);

  sir_state_e         state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;
  logic               sir_sel_q, sir_sel_d;
  logic [ADDR_W-1:0]  sir_addr_q, sir_addr_d;
  logic               sir_read_q, sir_read_d;
  logic [DATA_W-1:0]  sir_wdat_q, sir_wdat_d;
  logic [DATA_W-1:0]  req_rdat_q, req_rdat_d;
  logic [N_REQ-1:0]   req_dack_q, req_dack_d;
  logic [N_REQ-1:0]   req_err_q, req_err_d;
  logic               busy_q, busy_d;
  logic [15:0]        timeout_cnt_q, timeout_cnt_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;

  sir_rr_pick #(.N(N_REQ)) u_pick (
    .req   (req_sel),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    sir_sel_d     = sir_sel_q;
    sir_addr_d    = sir_addr_q;
    sir_read_d    = sir_read_q;
    sir_wdat_d    = sir_wdat_q;
    req_rdat_d    = req_rdat_q;
    req_dack_d    = '0;
    req_err_d     = '0;
    timeout_cnt_d = timeout_cnt_q;
    wd_cnt_d      = wd_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          sir_sel_d  = 1'b1;
          sir_addr_d = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          sir_read_d = req_read[pick_idx];
          sir_wdat_d = req_wdat[int'(pick_idx)*DATA_W +: DATA_W];
          grant_id_d = pick_idx;
          rr_ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          wd_cnt_d   = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // An acknowledge in the expiry cycle still counts as a normal completion.
        if (sir_dack) begin
          sir_sel_d              = 1'b0;
          req_rdat_d             = sir_read_q ? sir_rdat : '0;
          req_dack_d[grant_id_q] = 1'b1;
          state_d                = ST_DONE;
        end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
          sir_sel_d              = 1'b0;
          req_rdat_d             = ERR_RDATA;
          req_dack_d[grant_id_q] = 1'b1;
          req_err_d[grant_id_q]  = 1'b1;
          timeout_cnt_d          = (&timeout_cnt_q) ? timeout_cnt_q
                                                    : timeout_cnt_q + 16'd1;
          state_d                = ST_DONE;
        end
      end
      ST_DONE: begin
        wd_cnt_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      sir_sel_q     <= 1'b0;
      sir_addr_q    <= '0;
      sir_read_q    <= 1'b0;
      sir_wdat_q    <= '0;
      req_rdat_q    <= '0;
      req_dack_q    <= '0;
      req_err_q     <= '0;
      busy_q        <= 1'b0;
      timeout_cnt_q <= '0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      sir_sel_q     <= sir_sel_d;
      sir_addr_q    <= sir_addr_d;
      sir_read_q    <= sir_read_d;
      sir_wdat_q    <= sir_wdat_d;
      req_rdat_q    <= req_rdat_d;
      req_dack_q    <= req_dack_d;
      req_err_q     <= req_err_d;
      busy_q        <= busy_d;
      timeout_cnt_q <= timeout_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign sir_sel     = sir_sel_q;
  assign sir_addr    = sir_addr_q;
  assign sir_read    = sir_read_q;
  assign sir_wdat    = sir_wdat_q;
  assign req_rdat    = req_rdat_q;
  assign req_dack    = req_dack_q;
  assign req_err     = req_err_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_sir_arbiter.sv
// Self-checking bench for sir_arbiter: table-driven single transactions plus
// multi-requester, timeout and reset sequences, checked through a scoreboard.
module tb_sir_arbiter;

  localparam int N     = 4;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_sel;
  logic [N*AW-1:0]  req_addr;
  logic [N-1:0]     req_read;
  logic [N*DW-1:0]  req_wdat;
  logic [DW-1:0]    req_rdat;
  logic [N-1:0]     req_dack;
  logic [N-1:0]     req_err;
  logic             sir_sel;
  logic [AW-1:0]    sir_addr;
  logic             sir_read;
  logic [DW-1:0]    sir_wdat;
  logic [DW-1:0]    sir_rdat;
  logic             sir_dack;
  logic [1:0]       grant_id;
  logic             busy;
  logic [15:0]      timeout_cnt;

  sir_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_sel(req_sel), .req_addr(req_addr), .req_read(req_read), .req_wdat(req_wdat),
    .req_rdat(req_rdat), .req_dack(req_dack), .req_err(req_err),
    .sir_sel(sir_sel), .sir_addr(sir_addr), .sir_read(sir_read), .sir_wdat(sir_wdat),
    .sir_rdat(sir_rdat), .sir_dack(sir_dack),
    .grant_id(grant_id), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] addr;
    logic        rd;
    logic [31:0] wdat;
    int          dly;
    logic [31:0] srdat;
    logic [31:0] exp_rdat;
    logic        exp_err;
    int          exp_len;
    logic [15:0] exp_tocnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] addr;
    logic        rd;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        err;
    int          len;
  } exp_t;

  exp_t  sb[$];
  vec_t  tbl[5];
  int    compared = 0;
  int    errors   = 0;
  int    rem[N];
  logic  slv_en;
  int    slv_dly;
  int    scnt;
  logic [31:0] slv_rdat;
  logic  prev_sel;
  int    run, last_len;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic rd, input logic [31:0] wd);
    req_addr[i*AW +: AW] = a;
    req_read[i]          = rd;
    req_wdat[i*DW +: DW] = wd;
  endtask

  // Expected completion for requester i given its current fields and slave delay.
  function automatic exp_t mk(input int i, input int dly);
    exp_t e;
    e.idx  = i;
    e.addr = req_addr[i*AW +: AW];
    e.rd   = req_read[i];
    e.wdat = req_wdat[i*DW +: DW];
    e.err  = (dly >= TO);
    e.len  = e.err ? TO : dly + 1;
    e.rdat = e.err ? 32'hFFFF_FFFF : (e.rd ? slv_rdat : 32'h0);
    return e;
  endfunction

  function automatic bit any_rem();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) if (rem[i] != 0) r = 1'b1;
    return r;
  endfunction

  // One clock: sample on the falling edge, check against the scoreboard, then
  // drive the slave model and requester releases for the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      run      = 0;
      prev_sel = 1'b0;
    end else begin
      if (sir_sel && !prev_sel) begin
        if (sb.size() == 0) begin
          compared++; errors++;
          $display("FAIL unexpected_grant: got grant_id %0d expected none", grant_id);
        end else begin
          chk("grant_id", 64'(grant_id), 64'(sb[0].idx));
          chk("sir_addr", 64'(sir_addr), 64'(sb[0].addr));
          chk("sir_read", 64'(sir_read), 64'(sb[0].rd));
          chk("sir_wdat", 64'(sir_wdat), 64'(sb[0].wdat));
        end
      end
      if (sir_sel) run++;
      else if (run != 0) begin
        last_len = run;
        run      = 0;
      end
      if (req_dack != '0 || req_err != '0) begin
        if (sb.size() == 0) begin
          compared++; errors++;
          $display("FAIL unexpected_dack: got dack %0h err %0h expected none", req_dack, req_err);
        end else begin
          e = sb.pop_front();
          chk("req_dack", 64'(req_dack), 64'(1 << e.idx));
          chk("req_err", 64'(req_err), e.err ? 64'(1 << e.idx) : 64'h0);
          chk("req_rdat", 64'(req_rdat), 64'(e.rdat));
          chk("sel_len", 64'(last_len), 64'(e.len));
          chk("busy_done", 64'(busy), 64'h1);
          if (rem[e.idx] > 0) begin
            rem[e.idx]--;
            if (rem[e.idx] == 0) req_sel[e.idx] = 1'b0;
          end
        end
      end
      prev_sel = sir_sel;
    end
    if (slv_en) begin
      if (sir_sel) begin
        sir_dack = (scnt == slv_dly);
        sir_rdat = (scnt == slv_dly) ? slv_rdat : 32'h0;
        scnt++;
      end else begin
        sir_dack = 1'b0;
        scnt     = 0;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (any_rem() && c < budget) begin
      tick();
      c++;
    end
    if (any_rem()) begin
      compared++; errors++;
      $display("FAIL wait_budget: got pending requests after %0d cycles expected none", budget);
      for (int i = 0; i < N; i++) rem[i] = 0;
      req_sel = '0;
    end
    tick();
    tick();
  endtask

  initial begin
    tbl[0] = '{idx:1, addr:16'h0040, rd:1'b1, wdat:32'h0,         dly:3,     srdat:32'h1234_5678,
               exp_rdat:32'h1234_5678, exp_err:1'b0, exp_len:4, exp_tocnt:16'd0};
    tbl[1] = '{idx:2, addr:16'h0010, rd:1'b0, wdat:32'hDEAD_BEEF, dly:0,     srdat:32'h5555_AAAA,
               exp_rdat:32'h0,         exp_err:1'b0, exp_len:1, exp_tocnt:16'd0};
    tbl[2] = '{idx:0, addr:16'h00FC, rd:1'b0, wdat:32'h0BAD_F00D, dly:NEVER, srdat:32'h0,
               exp_rdat:32'hFFFF_FFFF, exp_err:1'b1, exp_len:8, exp_tocnt:16'd1};
    tbl[3] = '{idx:3, addr:16'h0020, rd:1'b1, wdat:32'h0,         dly:7,     srdat:32'hCAFE_F00D,
               exp_rdat:32'hCAFE_F00D, exp_err:1'b0, exp_len:8, exp_tocnt:16'd1};
    tbl[4] = '{idx:0, addr:16'h0044, rd:1'b1, wdat:32'h0,         dly:1,     srdat:32'h0102_0304,
               exp_rdat:32'h0102_0304, exp_err:1'b0, exp_len:2, exp_tocnt:16'd1};

    rst_n    = 1'b0;
    req_sel  = '0;
    req_addr = '0;
    req_read = '0;
    req_wdat = '0;
    sir_rdat = '0;
    sir_dack = 1'b0;
    slv_en   = 1'b1;
    slv_dly  = 0;
    slv_rdat = '0;
    scnt     = 0;
    prev_sel = 1'b0;
    run      = 0;
    last_len = 0;
    for (int i = 0; i < N; i++) rem[i] = 0;

    repeat (2) @(negedge clk);
    chk("rst_sir_sel", 64'(sir_sel), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_timeout_cnt", 64'(timeout_cnt), 64'h0);
    chk("rst_req_dack", 64'(req_dack), 64'h0);
    chk("rst_grant_id", 64'(grant_id), 64'h0);
    chk("rst_sir_addr", 64'(sir_addr), 64'h0);
    rst_n = 1'b1;
    tick();

    // All four at once: grant order 0,1,2,3 from rr_ptr=0.
    slv_dly  = 1;
    slv_rdat = 32'h7777_0001;
    for (int i = 0; i < N; i++) set_req(i, 16'h0100 + 16'(i * 4), i[0], 32'hA000_0000 + 32'(i));
    for (int i = 0; i < N; i++) begin
      sb.push_back(mk(i, slv_dly));
      rem[i] = 1;
    end
    req_sel = '1;
    wait_idle(200);
    chk("sim_drained", 64'(sb.size()), 64'h0);

    // Requesters 0 and 2 held for 10 transactions: strict alternation.
    slv_dly  = 0;
    slv_rdat = 32'h2222_0000;
    set_req(0, 16'h0200, 1'b1, 32'h0);
    set_req(2, 16'h0208, 1'b0, 32'h5A5A_0002);
    for (int k = 0; k < 10; k++) sb.push_back(mk((k % 2 == 0) ? 0 : 2, slv_dly));
    rem[0]  = 5;
    rem[2]  = 5;
    req_sel = 4'b0101;
    wait_idle(300);
    chk("fair_drained", 64'(sb.size()), 64'h0);

    for (int r = 0; r < 5; r++) begin
      set_req(tbl[r].idx, tbl[r].addr, tbl[r].rd, tbl[r].wdat);
      slv_dly  = tbl[r].dly;
      slv_rdat = tbl[r].srdat;
      sb.push_back('{idx:tbl[r].idx, addr:tbl[r].addr, rd:tbl[r].rd, wdat:tbl[r].wdat,
                     rdat:tbl[r].exp_rdat, err:tbl[r].exp_err, len:tbl[r].exp_len});
      rem[tbl[r].idx]     = 1;
      req_sel[tbl[r].idx] = 1'b1;
      tick();
      chk("req_latency", 64'(sir_sel), 64'h1);
      wait_idle(60);
      chk("timeout_cnt", 64'(timeout_cnt), 64'(tbl[r].exp_tocnt));
    end
    chk("tbl_drained", 64'(sb.size()), 64'h0);

    // Stray acknowledge while idle must produce nothing.
    slv_en   = 1'b0;
    sir_dack = 1'b1;
    sir_rdat = 32'hBAD0_BAD0;
    tick();
    sir_dack = 1'b0;
    tick();
    tick();
    chk("stray_dack", 64'(req_dack), 64'h0);
    chk("stray_busy", 64'(busy), 64'h0);
    chk("stray_rdat", 64'(req_rdat), 64'h0102_0304);
    slv_en = 1'b1;

    // Reset while a transaction is outstanding, then restart from requester 0.
    set_req(1, 16'h0300, 1'b0, 32'h0000_0011);
    slv_dly = NEVER;
    sb.push_back(mk(1, slv_dly));
    rem[1]  = 1;
    req_sel = 4'b0010;
    repeat (3) tick();
    chk("pre_rst_sel", 64'(sir_sel), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_sir_sel", 64'(sir_sel), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_sir_addr", 64'(sir_addr), 64'h0);
    chk("arst_sir_wdat", 64'(sir_wdat), 64'h0);
    chk("arst_req_rdat", 64'(req_rdat), 64'h0);
    chk("arst_timeout_cnt", 64'(timeout_cnt), 64'h0);
    chk("arst_grant_id", 64'(grant_id), 64'h0);
    sb.delete();
    rem[1]   = 0;
    slv_dly  = 2;
    slv_rdat = 32'h0330_0330;
    set_req(0, 16'h0400, 1'b1, 32'h0);
    set_req(3, 16'h040C, 1'b0, 32'h0000_0333);
    sb.push_back(mk(0, slv_dly));
    sb.push_back(mk(3, slv_dly));
    rem[0]  = 1;
    rem[3]  = 1;
    req_sel = 4'b1001;
    tick();
    chk("rst_no_dack", 64'(req_dack), 64'h0);
    rst_n = 1'b1;
    wait_idle(100);
    chk("rst_drained", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule
